div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle iterative divider sequencer serving the EX stage for DIV/DIVU.
- EX raises `start_i` and stalls the pipeline until `ready_o`. The 64-bit result {remainder, quotient} is then written to HI/LO through the normal whilo path.
- The block owns the FSM, iteration counter, operand latches and sign fix-up. It accepts a flush (`annul_i`) from the pipeline controller.

Parameters:
- WIDTH, 32, operand width. Result width is 2*WIDTH. The iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-high reset: 1 = reset asserted.
- signed_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request; held high by EX until it has consumed the result.
- annul_i  input  1  flush; aborts any operation in progress.
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- ready_o  output  1  result valid.
- busy_o  output  1  operation in progress (IDLE excluded); EX ORs this into `stallreq`.

Behaviour:
- States: IDLE, BYZERO, ON, END. Reset forces IDLE, counter=0, internal dividend register=0, `result_o`=0, `ready_o`=0, `busy_o`=0. This takes effect immediately, including mid-operation.
- IDLE:
  - If `start_i`=1 and `annul_i`=0 at a rising edge, latch the operands.
  - Signed mode with a negative operand: latch its two's-complement magnitude and keep the original sign bits.
  - Divisor = 0 → BYZERO. Otherwise → ON, counter=0, partial remainder=0.
  - `annul_i`=1 has priority over `start_i`: nothing is accepted.
- BYZERO: next edge → END with result forced to 0. No trap is generated.
- ON:
  - One restoring radix-2 step per cycle. Shift {rem, dividend} left by 1, then trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the difference is non-negative, keep it and set quotient LSB=1; otherwise restore and set quotient LSB=0. Counter increments.
  - After the WIDTH-th step → END.
  - `annul_i`=1 in any ON cycle → IDLE at that edge; result is discarded and `ready_o` is never asserted.
- END:
  - `ready_o`=1 and `result_o` is driven.
  - Signed fix-up: quotient is negated if the latched signs differ. Remainder takes the dividend's sign (negated if the dividend was negative).
  - Remains in END while `start_i`=1. `start_i`=0 → IDLE and `ready_o` drops at that edge. `annul_i`=1 → IDLE.
- Output rules:
  - `result_o` = 0 and `ready_o` = 0 in every state except END.
  - `busy_o` = 1 in BYZERO and ON, and in END while `start_i`=1.
- Latency:
  - Start sampled at edge k gives `ready_o` high after edge k+WIDTH+1 (33 cycles for WIDTH=32).
  - Divide-by-zero gives `ready_o` high after edge k+2.
- Operand changes after acceptance are ignored until the next IDLE acceptance.
- Overflow wrap: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. Magnitude arithmetic is WIDTH-bit modulo; no exception is raised.
- A new operation can be accepted no earlier than the cycle after returning to IDLE. `start_i` held high continuously therefore never re-triggers without passing through IDLE.

Test Plan:
- Unsigned 100 / 7 (signed_i=0), start held → `ready_o` rises 33 cycles after accept; `result_o` = {0x00000002, 0x0000000E}; drop start → IDLE next edge, outputs 0.
- Signed -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (0x1234 / 0) → `ready_o` after 2 edges, `result_o` = 0; `busy_o` high for 2 cycles.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Assert `annul_i` on the 10th ON cycle → IDLE next edge, `ready_o` never rises. Then a new start of 9 / 3 completes with quotient 3, remainder 0 in 33 cycles.
- Assert `resetn`=1 asynchronously mid-ON (not edge-aligned) → all outputs 0 immediately. After release, a start is accepted normally. Also check `start_i` and `annul_i` both high in IDLE → no acceptance.

Source files
------------

// File: rtl/div_seq.sv
// div_seq -- multi-cycle restoring divider for DIV / DIVU in the EX stage.
//
// EX raises start_i and stalls on busy_o until ready_o. The divider works on
// operand magnitudes, one quotient bit per cycle, then applies the sign
// fix-up when presenting the result. annul_i (pipeline flush) drops any
// operation in progress without ever raising ready_o.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous reset, active high (1 = reset asserted)
//   signed_i   1 = DIV (signed), 0 = DIVU
//   opdata1_i  dividend
//   opdata2_i  divisor
//   start_i    request, held high by EX until the result is consumed
//   annul_i    flush, aborts any operation in progress
//   result_o   {remainder, quotient}, zero unless ready_o
//   ready_o    result valid
//   busy_o     operation in progress (EX ORs this into its stall request)
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    // dend_reg starts as the dividend magnitude; quotient bits shift in at
    // its LSB, so after WIDTH steps it holds the quotient magnitude.
    logic [WIDTH-1:0]   dend_reg, dend_next;
    logic [WIDTH-1:0]   rem_reg, rem_next;
    logic [WIDTH-1:0]   dsor_reg, dsor_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               ready_reg, ready_next;

    // Operand magnitudes (only negated for signed mode with a negative value).
    logic [WIDTH-1:0]   mag1, mag2;
    assign mag1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // One restoring step: the partial remainder gains the next dividend bit,
    // giving a WIDTH+1 bit value to compare against the divisor.
    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   rem_sub;
    assign shifted = {rem_reg, dend_reg[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dsor_reg});
    // When fits is set the difference is below the divisor, so its low
    // WIDTH bits are exact.
    assign rem_sub = shifted[WIDTH-1:0] - dsor_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dend_next  = dend_reg;
        rem_next   = rem_reg;
        dsor_next  = dsor_reg;
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;

        case (state_reg)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    dend_next  = mag1;
                    dsor_next  = mag2;
                    rem_next   = '0;
                    cnt_next   = '0;
                    neg_q_next = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r_next = signed_i & opdata1_i[WIDTH-1];
                    state_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                // Divide by zero yields an all-zero result, no trap.
                dend_next  = '0;
                rem_next   = '0;
                neg_q_next = 1'b0;
                neg_r_next = 1'b0;
                state_next = annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_next = S_IDLE;
                end else begin
                    if (fits) begin
                        rem_next  = rem_sub;
                        dend_next = {dend_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_next  = shifted[WIDTH-1:0];
                        dend_next = {dend_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_next = S_END;
                    end
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ready_o is registered: it rises on the edge after END is entered and
    // falls on the same edge that leaves END.
    assign ready_next = (state_reg == S_END) && (state_next == S_END);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            dend_reg  <= '0;
            rem_reg   <= '0;
            dsor_reg  <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dend_reg  <= dend_next;
            rem_reg   <= rem_next;
            dsor_reg  <= dsor_next;
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
            ready_reg <= ready_next;
        end
    end

    // Sign fix-up: quotient negative when operand signs differ, remainder
    // follows the dividend's sign. Magnitudes wrap modulo 2^WIDTH, which
    // makes the most-negative / -1 case come out as the most-negative value.
    logic [WIDTH-1:0] quo_fix, rem_fix;
    assign quo_fix = neg_q_reg ? -dend_reg : dend_reg;
    assign rem_fix = neg_r_reg ? -rem_reg  : rem_reg;

    assign ready_o  = ready_reg;
    assign result_o = ready_reg ? {rem_fix, quo_fix} : '0;
    assign busy_o   = (state_reg == S_BYZERO) || (state_reg == S_ON) ||
                      ((state_reg == S_END) && start_i);

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed corner cases plus random operations.
// Expected results come from plain integer division in the bench; a monitor
// process matches each rising ready_o against a queue of expected results.
module tb_div_seq;

    localparam int W = 32;

    logic           clk;
    logic           resetn;
    logic           signed_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;

    div_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    typedef struct {
        logic [2*W-1:0] res;
        int             due;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: language-level integer division. Truncation toward zero and
    // a dividend-signed remainder are exactly the DIV/DIVU semantics.
    function automatic logic [2*W-1:0] ref_div(input bit sgn, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint q;
        longint r;
        if (b == '0) return '0;
        if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'b0, a}) / longint'({32'b0, b});
            r = longint'({32'b0, a}) % longint'({32'b0, b});
        end
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Monitor: one line per completed transaction.
    initial begin
        bit   ready_prev;
        exp_t e;
        ready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                ready_prev = 1'b0;
            end else begin
                if (ready_o && !ready_prev) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_ready", 64'(ready_o), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn: result=%h expected=%h at cycle %0d (due %0d)",
                                 result_o, e.res, cyc, e.due);
                        check("result", result_o, e.res);
                        check("latency", 64'(cyc), 64'(e.due));
                    end
                end
                if (!ready_o) check("result_zero_when_not_ready", result_o, 64'd0);
                ready_prev = ready_o;
            end
        end
    end

    // Issue one operation (called at a negedge with the DUT idle). Operands
    // are scrambled while the DUT works to show they are latched.
    task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit reset_in_end);
        exp_t e;
        bit   busy_bad;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        e.res = ref_div(sgn, a, b);
        e.due = cyc + 1 + ((b == '0) ? 2 : W + 1);
        sb_q.push_back(e);
        busy_bad = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 60 && !ready_o; i++) begin
            if (!busy_o) busy_bad = 1'b1;
            signed_i  = 1'($urandom_range(0, 1));
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            @(negedge clk);
        end
        check("ready_timeout", 64'(ready_o), 64'd1);
        check("busy_while_working", 64'(busy_bad), 64'd0);
        repeat (2) @(negedge clk);
        check("hold_in_end", 64'({ready_o, busy_o}), 64'b11);
        if (reset_in_end) begin
            #2 resetn = 1'b1;
            #1 check("async_reset_in_end", {result_o[61:0], ready_o, busy_o}, 64'd0);
            start_i = 1'b0;
            @(negedge clk);
            #2 resetn = 1'b0;
            @(negedge clk);
        end else begin
            start_i = 1'b0;
            @(negedge clk);
            check("drop_start_idle", {result_o[61:0], ready_o, busy_o}, 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sgn;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sgn;
        n_cmp     = 0;
        n_err     = 0;
        resetn    = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {result_o[61:0], ready_o, busy_o}, 64'd0);
        resetn = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(1'b0, 32'd100, 32'd7, 1'b0);
        run_op(1'b1, -32'sd7, 32'd2, 1'b0);
        run_op(1'b1, 32'd7, -32'sd2, 1'b0);
        run_op(1'b0, 32'h1234, 32'd0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);

        // Flush on the 10th ON cycle: no result may ever appear.
        signed_i  = 1'b0;
        opdata1_i = 32'd5000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_to_idle", 64'({ready_o, busy_o}), 64'd0);
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd9, 32'd3, 1'b0);

        // Asynchronous reset in the middle of ON, off the clock edges.
        signed_i  = 1'b1;
        opdata1_i = 32'd123456;
        opdata2_i = -32'sd77;
        start_i   = 1'b1;
        repeat (12) @(negedge clk);
        #2 resetn = 1'b1;
        #1 check("async_reset_in_on", {result_o[61:0], ready_o, busy_o}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        run_op(1'b1, 32'd1000, 32'd33, 1'b0);
        run_op(1'b0, 32'hDEAD_BEEF, 32'd16, 1'b1);
        run_op(1'b0, 32'd77, 32'd5, 1'b0);

        // start and annul together in IDLE: nothing accepted.
        start_i = 1'b1;
        annul_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("start_annul_idle", 64'({ready_o, busy_o}), 64'd0);
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (40) @(negedge clk);

        // Random operations
        for (int n = 0; n < 30; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = (($urandom_range(0, 3)) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(sgn, a, b, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
